boule_rouge_spawner: RTL

Upstream controller for `boule_rouge_layer`. It decides when a red ball appears, where it starts, and which six-step path it takes. It drives `e_enable_br`, `e_XY0_br` and `e_move_br` from a free-running LFSR and a randomised spawn countdown. It holds each request until the layer accepts it, then waits for the ball to finish before scheduling the next one.

---
 rtl/qbert_pkg.sv | 17 +
 rtl/lfsr16.sv | 20 ++
 rtl/boule_rouge_spawner.sv | 105 ++++++++++
 3 files changed

// File: rtl/qbert_pkg.sv
// Types and constants shared by the Q*bert enemy spawners.
package qbert_pkg;

  typedef enum logic [1:0] {OFF, WAIT, ARM, ACTIVE} spawn_state_t;
  typedef enum logic {RUN, PAUSE} game_state_t;

  // Feedback taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Integrator guarantees the sum never wraps.
  function automatic logic [31:0] countdown_load(input logic [31:0] base,
                                                 input logic [3:0]  nib,
                                                 input logic [4:0]  shift);
    return base + ({28'b0, nib} << shift);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left every cycle.
module lfsr16
  import qbert_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/boule_rouge_spawner.sv
// Red-ball spawn controller: randomised countdown, request/accept handshake with the
// ball layer, and a RUN/PAUSE mirror of the game state.
module boule_rouge_spawner
  import qbert_pkg::*;
#(
  parameter logic [31:0] BASE_DELAY   = 32'd50_000_000,
  parameter logic [4:0]  JITTER_SHIFT = 5'd22,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter logic [7:0]  MAX_SPAWN    = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_start_qb,
  input  logic        e_pause_qb,
  input  logic        e_resume_qb,
  input  logic        e_allow_br,
  input  logic        freeze_power,
  input  logic [20:0] XY_top,
  input  logic        br_end,
  output logic        e_enable_br,
  output logic [5:0]  e_move_br,
  output logic [20:0] e_XY0_br,
  output logic [7:0]  spawn_cnt,
  output logic        spawner_busy
);

  logic [15:0]  lfsr;
  logic [31:0]  countdown;
  logic [31:0]  load_val;
  spawn_state_t state;
  game_state_t  game;
  logic         unused_lfsr_bits;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr)
  );

  assign load_val         = countdown_load(BASE_DELAY, lfsr[15:12], JITTER_SHIFT);
  assign unused_lfsr_bits = ^lfsr[11:6];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= OFF;
      game         <= RUN;
      countdown    <= 32'd0;
      e_enable_br  <= 1'b0;
      e_move_br    <= 6'd0;
      e_XY0_br     <= 21'd0;
      spawn_cnt    <= 8'd0;
      spawner_busy <= 1'b0;
    end else if (e_start_qb) begin
      // A start always wins: any pending request is withdrawn.
      state        <= WAIT;
      game         <= RUN;
      countdown    <= load_val;
      spawn_cnt    <= 8'd0;
      e_enable_br  <= 1'b0;
      spawner_busy <= 1'b0;
    end else begin
      if (e_pause_qb) begin
        game <= PAUSE;
      end else if (e_resume_qb) begin
        game <= RUN;
      end
      if (game == RUN) begin
        case (state)
          WAIT: begin
            if (!freeze_power && e_allow_br) begin
              if (countdown == 32'd0) begin
                state        <= ARM;
                e_move_br    <= lfsr[5:0];
                e_XY0_br     <= XY_top;
                e_enable_br  <= 1'b1;
                spawner_busy <= 1'b1;
                spawn_cnt    <= (spawn_cnt < MAX_SPAWN) ? spawn_cnt + 8'd1 : MAX_SPAWN;
              end else begin
                countdown <= countdown - 32'd1;
              end
            end
          end
          // First sample here is one cycle after entry, so a stale level is never taken.
          ARM: begin
            if (!br_end) begin
              state       <= ACTIVE;
              e_enable_br <= 1'b0;
            end
          end
          ACTIVE: begin
            if (br_end) begin
              state        <= WAIT;
              countdown    <= load_val;
              spawner_busy <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
